// File: rtl/count_step_decoder.sv
// Step estimator for a signed 8-bit counter stream: recovers the per-sample
// increment (modulo 256), declares lock after LOCK_N equal steps and flags breaks.
module count_step_decoder #(
  parameter int LOCK_N = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Clear,
  input  logic       Sample_En,
  input  logic [7:0] Count_In,
  output logic [7:0] Step_Out,
  output logic       Step_Valid,
  output logic       Locked,
  output logic [7:0] Locked_Step,
  output logic       Step_Err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TRACK  = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_RUN = 4'(LOCK_N);

  state_t     state_reg, state_next;
  logic [7:0] prev_reg, prev_next;
  logic [7:0] last_diff_reg, last_diff_next;
  logic [3:0] run_reg, run_next;
  logic [7:0] step_out_reg, step_out_next;
  logic       step_valid_reg, step_valid_next;
  logic       locked_reg, locked_next;
  logic [7:0] locked_step_reg, locked_step_next;
  logic       step_err_reg, step_err_next;

  logic [7:0] diff;
  logic [3:0] run_inc;

  // Unsigned 8-bit subtraction wraps naturally; reading the result as
  // two's complement gives the signed step, including -128.
  assign diff = Count_In - prev_reg;

  always_comb begin
    run_inc = 4'd1;
    if (run_reg != 4'd0 && diff == last_diff_reg) begin
      if (run_reg >= LOCK_RUN) begin
        run_inc = LOCK_RUN;
      end else begin
        run_inc = run_reg + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg       <= S_IDLE;
      prev_reg        <= 8'd0;
      last_diff_reg   <= 8'd0;
      run_reg         <= 4'd0;
      step_out_reg    <= 8'd0;
      step_valid_reg  <= 1'b0;
      locked_reg      <= 1'b0;
      locked_step_reg <= 8'd0;
      step_err_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      prev_reg        <= prev_next;
      last_diff_reg   <= last_diff_next;
      run_reg         <= run_next;
      step_out_reg    <= step_out_next;
      step_valid_reg  <= step_valid_next;
      locked_reg      <= locked_next;
      locked_step_reg <= locked_step_next;
      step_err_reg    <= step_err_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    prev_next        = prev_reg;
    last_diff_next   = last_diff_reg;
    run_next         = run_reg;
    step_out_next    = step_out_reg;
    step_valid_next  = 1'b0;
    locked_next      = locked_reg;
    locked_step_next = locked_step_reg;
    step_err_next    = 1'b0;

    if (Clear) begin
      // A sample coinciding with Clear is dropped; step history is kept.
      state_next  = S_IDLE;
      run_next    = 4'd0;
      locked_next = 1'b0;
    end else if (Sample_En) begin
      case (state_reg)
        S_IDLE: begin
          prev_next  = Count_In;
          run_next   = 4'd0;
          state_next = S_TRACK;
        end
        S_TRACK: begin
          prev_next       = Count_In;
          step_out_next   = diff;
          step_valid_next = 1'b1;
          run_next        = run_inc;
          last_diff_next  = diff;
          if (run_inc == LOCK_RUN) begin
            state_next       = S_LOCKED;
            locked_next      = 1'b1;
            locked_step_next = diff;
          end
        end
        S_LOCKED: begin
          prev_next       = Count_In;
          step_out_next   = diff;
          step_valid_next = 1'b1;
          if (diff != locked_step_reg) begin
            step_err_next  = 1'b1;
            locked_next    = 1'b0;
            state_next     = S_TRACK;
            run_next       = 4'd1;
            last_diff_next = diff;
          end
        end
        default: begin
          state_next = S_IDLE;
          run_next   = 4'd0;
        end
      endcase
    end
  end

  assign Step_Out    = step_out_reg;
  assign Step_Valid  = step_valid_reg;
  assign Locked      = locked_reg;
  assign Locked_Step = locked_step_reg;
  assign Step_Err    = step_err_reg;

endmodule

// File: tb/tb_count_step_decoder.sv
// Scoreboard bench for count_step_decoder: a behavioural model queues the
// expected outputs per driven cycle; they are popped and checked after the edge.
module tb_count_step_decoder;

  localparam int LOCK_N = 4;

  logic       CLK;
  logic       RST;
  logic       Clear;
  logic       Sample_En;
  logic [7:0] Count_In;
  logic [7:0] Step_Out;
  logic       Step_Valid;
  logic       Locked;
  logic [7:0] Locked_Step;
  logic       Step_Err;

  count_step_decoder #(.LOCK_N(LOCK_N)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Clear      (Clear),
    .Sample_En  (Sample_En),
    .Count_In   (Count_In),
    .Step_Out   (Step_Out),
    .Step_Valid (Step_Valid),
    .Locked     (Locked),
    .Locked_Step(Locked_Step),
    .Step_Err   (Step_Err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int step;
    int valid;
    int locked;
    int lstep;
    int err;
  } exp_t;

  exp_t sb_q[$];

  int n_vec = 0;
  int n_err = 0;
  int valid_cnt = 0;
  int err_cnt = 0;

  // Reference model state: 0 = idle, 1 = tracking, 2 = locked
  int m_state, m_prev, m_last, m_run, m_step, m_lstep, m_locked;

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int to_s8(input int v);
    int m;
    m = v & 255;
    return (m > 127) ? m - 256 : m;
  endfunction

  task automatic model_reset();
    m_state = 0; m_prev = 0; m_last = 0; m_run = 0;
    m_step = 0; m_lstep = 0; m_locked = 0;
  endtask

  task automatic model_push(input bit en, input bit clr, input int cnt);
    exp_t e;
    int d;
    e.valid = 0;
    e.err = 0;
    if (clr) begin
      m_state = 0; m_run = 0; m_locked = 0;
    end else if (en) begin
      d = to_s8(cnt - m_prev);
      if (m_state == 0) begin
        m_prev = to_s8(cnt); m_run = 0; m_state = 1;
      end else if (m_state == 1) begin
        m_prev = to_s8(cnt); m_step = d; e.valid = 1;
        if (m_run > 0 && d == m_last) m_run = (m_run + 1 > LOCK_N) ? LOCK_N : m_run + 1;
        else m_run = 1;
        m_last = d;
        if (m_run == LOCK_N) begin
          m_state = 2; m_locked = 1; m_lstep = d;
        end
      end else begin
        m_prev = to_s8(cnt); m_step = d; e.valid = 1;
        if (d != m_lstep) begin
          e.err = 1; m_locked = 0; m_state = 1; m_run = 1; m_last = d;
        end
      end
    end
    e.step = m_step;
    e.locked = m_locked;
    e.lstep = m_lstep;
    sb_q.push_back(e);
  endtask

  // Called at a negedge; returns at the following negedge after checking.
  task automatic drive(input bit en, input bit clr, input int cnt);
    exp_t e;
    Sample_En = en;
    Clear = clr;
    Count_In = 8'(cnt);
    model_push(en, clr, cnt);
    @(posedge CLK);
    @(negedge CLK);
    e = sb_q.pop_front();
    check_val("step_out", int'($signed(Step_Out)), e.step);
    check_val("step_valid", int'(Step_Valid), e.valid);
    check_val("locked", int'(Locked), e.locked);
    check_val("locked_step", int'($signed(Locked_Step)), e.lstep);
    check_val("step_err", int'(Step_Err), e.err);
    valid_cnt += int'(Step_Valid);
    err_cnt += int'(Step_Err);
    $display("txn en=%0d clr=%0d cnt=%0d -> step=%0d valid=%0d locked=%0d lstep=%0d err=%0d",
             en, clr, cnt, $signed(Step_Out), Step_Valid, Locked, $signed(Locked_Step), Step_Err);
  endtask

  task automatic feed(input int vals[]);
    foreach (vals[i]) drive(1'b1, 1'b0, vals[i]);
  endtask

  initial begin
    RST = 1'b1; Clear = 1'b0; Sample_En = 1'b0; Count_In = 8'd0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    check_val("rst_step_out", int'(Step_Out), 0);
    check_val("rst_valid", int'(Step_Valid), 0);
    check_val("rst_locked", int'(Locked), 0);
    check_val("rst_locked_step", int'(Locked_Step), 0);
    check_val("rst_err", int'(Step_Err), 0);
    RST = 1'b0;

    // Lock-in on +10
    valid_cnt = 0; err_cnt = 0;
    feed('{0, 10, 20, 30, 40});
    check_val("lockin_valid_pulses", valid_cnt, 4);
    check_val("lockin_locked", int'(Locked), 1);
    check_val("lockin_lstep", int'($signed(Locked_Step)), 10);

    // Wrap-around through +127/-128
    drive(1'b0, 1'b1, 0);
    valid_cnt = 0; err_cnt = 0;
    feed('{100, 110, 120, -126, -116});
    check_val("wrap_err_pulses", err_cnt, 0);
    check_val("wrap_locked", int'(Locked), 1);
    check_val("wrap_step", int'($signed(Step_Out)), 10);

    // Negative step, then -128 steps
    drive(1'b0, 1'b1, 0);
    valid_cnt = 0; err_cnt = 0;
    feed('{50, 40, 30, 20, 10});
    check_val("neg_lstep", int'($signed(Locked_Step)), -10);
    feed('{0, -128, 0});
    check_val("neg128_err_pulses", err_cnt, 1);
    check_val("neg128_step", int'($signed(Step_Out)), -128);
    check_val("neg128_locked", int'(Locked), 0);

    // Error and relock on +11
    drive(1'b0, 1'b1, 0);
    feed('{0, 10, 20, 30, 40});
    err_cnt = 0;
    feed('{51, 62, 73, 84});
    check_val("relock_err_pulses", err_cnt, 1);
    check_val("relock_locked", int'(Locked), 1);
    check_val("relock_lstep", int'($signed(Locked_Step)), 11);

    // Sparse sampling: 1 on, 2 off, with junk on Count_In while idle
    drive(1'b0, 1'b1, 0);
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b0, k * 7);
      drive(1'b0, 1'b0, int'($urandom_range(0, 255)));
      drive(1'b0, 1'b0, int'($urandom_range(0, 255)));
    end
    check_val("gap_lstep", int'($signed(Locked_Step)), 7);

    // Clear together with a sample while locked; next sample only primes
    drive(1'b1, 1'b1, 99);
    check_val("clr_locked", int'(Locked), 0);
    valid_cnt = 0;
    drive(1'b1, 1'b0, 5);
    check_val("clr_prime_no_valid", valid_cnt, 0);
    drive(1'b1, 1'b0, 8);

    // Asynchronous reset mid-lock
    drive(1'b0, 1'b1, 0);
    feed('{0, 3, 6, 9, 12});
    check_val("prerst_locked", int'(Locked), 1);
    #2 RST = 1'b1;
    #1;
    check_val("arst_step_out", int'(Step_Out), 0);
    check_val("arst_valid", int'(Step_Valid), 0);
    check_val("arst_locked", int'(Locked), 0);
    check_val("arst_locked_step", int'(Locked_Step), 0);
    check_val("arst_err", int'(Step_Err), 0);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    feed('{15, 20, 25, 30});
    check_val("arst_not_yet_locked", int'(Locked), 0);
    feed('{35});
    check_val("arst_relocked", int'(Locked), 1);
    check_val("arst_relock_lstep", int'($signed(Locked_Step)), 5);

    check_val("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/count_step_decoder.md
# count_step_decoder

Receive-side companion to the signed 8-bit step counter. It samples the counter's signed `Count` stream and recovers the per-sample increment (`In`) that produced it, handling modulo-256 wrap-around. It declares lock once the increment is stable and flags any later deviation. It sits downstream of the counter, on the same `CLK`, as a self-checking monitor and step estimator.

## Interface
- `LOCK_N`, default 4: number of consecutive identical steps required to declare lock. Legal range 2..15.
- `CLK`  in  1: system clock; all state is updated on the rising edge.
- `RST`  in  1: asynchronous, active-high reset.
- `Clear`  in  1: synchronous soft restart to `IDLE`.
- `Sample_En`  in  1: when high, `Count_In` is sampled this cycle.
- `Count_In`  in  8 (signed): counter value.
- `Step_Out`  out  8 (signed): most recently decoded step.
- `Step_Valid`  out  1: one-cycle pulse when `Step_Out` is updated.
- `Locked`  out  1: high while the step is stable.
- `Locked_Step`  out  8 (signed): step captured at lock; held while `Locked` is high.
- `Step_Err`  out  1: one-cycle pulse when a locked step is broken.

## Operation
- Internal registers:
  - `prev` (8-bit): last sample.
  - `last_diff` (8-bit): previous step.
  - `run` (4-bit): count of consecutive equal steps, saturating at `LOCK_N`.
- Step arithmetic: `diff = Count_In - prev`, computed modulo 256 and interpreted as signed. A step of -128 is legal. Wrap-around decodes correctly; for example 120 -> -126 decodes as +10.
- FSM states: `IDLE`, `TRACK`, `LOCKED`.
- `IDLE`:
  - On `Sample_En`: `prev <= Count_In`, go to `TRACK`, `run <= 0`.
  - No `Step_Valid` is produced in this state.
- `TRACK`, on `Sample_En`:
  - Update `prev` and set `Step_Out <= diff`; pulse `Step_Valid`.
  - If `run == 0` or `diff != last_diff`: `run <= 1`.
  - Otherwise: `run <= run + 1`.
  - `last_diff <= diff`.
  - If the new `run` equals `LOCK_N`: go to `LOCKED`, set `Locked <= 1` and `Locked_Step <= diff`.
- `LOCKED`, on `Sample_En`:
  - Always: update `prev` and `Step_Out`; pulse `Step_Valid`.
  - If `diff == Locked_Step`: stay in `LOCKED`.
  - Otherwise: pulse `Step_Err`, clear `Locked`, go to `TRACK`, `run <= 1`, `last_diff <= diff`. `Locked_Step` keeps its stale value.
- `Clear`:
  - Returns the FSM to `IDLE` and zeroes `run`, `Locked`, `Step_Valid` and `Step_Err`.
  - `Step_Out` and `Locked_Step` hold their values.
  - `Clear` has priority over a simultaneous `Sample_En`; that sample is discarded.
- `Sample_En` low: nothing changes except that the `Step_Valid` and `Step_Err` pulses drop.
- Zero step: a constant count decodes as step 0 and can lock at 0.

## Timing
- Reset values: `Step_Out` = 0, `Step_Valid` = 0, `Locked` = 0, `Locked_Step` = 0, `Step_Err` = 0. FSM is in `IDLE`; `prev`, `last_diff` and `run` are 0.
- Reset acts immediately and asynchronously, including mid-lock. The first sample after reset release is treated as the `IDLE` priming sample.
- Latency: a sample taken at edge N drives `Step_Out` / `Step_Valid` after edge N, so they are visible in cycle N+1. Outputs are registered; there is no combinational input-to-output path.
- `Locked` rises on the same edge as the `Step_Valid` for the `LOCK_N`-th equal step. Lock therefore needs `LOCK_N`+1 samples after `IDLE`.
- `Step_Err` and the falling edge of `Locked` occur on the same edge as the offending `Step_Valid`.
- Back-to-back `Sample_En` on every cycle is supported; there is no throughput limit.

## Test plan
- Lock-in with `LOCK_N`=4: feed `Count_In` 0, 10, 20, 30, 40, one sample per cycle.
  - Required: `Step_Out` = 10 with four `Step_Valid` pulses.
  - Required: `Locked` rises with the fourth pulse, and `Locked_Step` = 10.
- Wrap-around: feed 100, 110, 120, -126, -116.
  - Required: every decoded step = +10.
  - Required: lock on the fourth step; no `Step_Err`.
- Negative step and -128: feed 50, 40, 30, 20, 10.
  - Required: step = -10; lock with `Locked_Step` = -10.
  - Then feed 0, -128, 0.
  - Required: steps -10, -128, -128; `Step_Err` pulses once on the -128.
- Error and relock: lock on step 10, then feed +11, +11, +11, +11 increments.
  - Required: `Step_Err` pulses once on the first +11 and `Locked` falls.
  - Required: relock with `Locked_Step` = 11 on the fourth +11 step.
- Gaps and Clear:
  - With `Sample_En` toggling 1 cycle on / 2 off: decoding is unaffected.
  - `Clear` asserted together with `Sample_En` mid-lock: FSM goes to `IDLE`, `Locked` = 0, and the next sample produces no `Step_Valid`.
- Asynchronous reset mid-lock: assert `RST` between clock edges.
  - Required: all outputs go to 0 before the next edge.
  - Required: after release, `LOCK_N`+1 samples are needed to relock.
